// File: rtl/blackjack_pkg.sv
// Shared card-game types and constants: deck geometry, LFSR seed, index helpers.
// Pure combinational helpers, no latency.
// No flow control; consumers call the helpers directly.
package blackjack_pkg;

  typedef logic [3:0] card_value_t;
  typedef logic [1:0] card_symbol_t;

  localparam int          DECK_SIZE = 52;
  localparam int          SUIT_SIZE = 13;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fold a raw 6-bit random number into the 0..51 card index range.
  function automatic logic [5:0] wrap_index(input logic [5:0] raw);
    return (raw >= 6'(DECK_SIZE)) ? raw - 6'(DECK_SIZE) : raw;
  endfunction

  // Suit of a card index (index div 13).
  function automatic card_symbol_t index_symbol(input logic [5:0] idx);
    if (idx >= 6'(3 * SUIT_SIZE)) return 2'd3;
    if (idx >= 6'(2 * SUIT_SIZE)) return 2'd2;
    if (idx >= 6'(SUIT_SIZE))     return 2'd1;
    return 2'd0;
  endfunction

  // Rank of a card index ((index mod 13) + 1).
  function automatic card_value_t index_value(input logic [5:0] idx);
    logic [5:0] base;
    base = 6'(SUIT_SIZE) * {4'd0, index_symbol(idx)};
    return 4'(idx - base + 6'd1);
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Card dealer request/response bundle: shuffle/draw pulses in, card and deck status out.
// No latency of its own.
// No backpressure: draw requests arriving while busy are dropped by the dealer.
interface card_dealer_if;
  import blackjack_pkg::*;

  logic         shuffle;
  logic         draw_req;
  logic         card_valid;
  card_value_t  card_value;
  card_symbol_t card_symbol;
  logic         busy;
  logic [5:0]   cards_left;
  logic         deck_empty;

  modport master (
    output shuffle, draw_req,
    input  card_valid, card_value, card_symbol, busy, cards_left, deck_empty
  );

  modport slave (
    input  shuffle, draw_req,
    output card_valid, card_value, card_symbol, busy, cards_left, deck_empty
  );

endinterface

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), reseeded by reset.
// Advances one step every clock; state visible the cycle after the edge.
// No backpressure; never stalls.
module lfsr16
  import blackjack_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = {fb, lfsr_q[15:1]};
  end

  // Seed on reset, step otherwise; a non-zero seed keeps it out of the all-zero lockup.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck using an LFSR start point and linear probe.
// Latency 2+k cycles from draw_req to card_valid (k = used slots skipped).
// No queueing: draw_req while busy or with an empty deck is dropped; shuffle aborts.
// Build option CARD_DEALER_FIXED_SEQ_EN: probe always starts at index 0 (lowest free card).
module card_dealer
  import blackjack_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  card_dealer_if.slave dif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]           state_q,      state_d;
  logic [5:0]           cand_q,       cand_d;
  logic [DECK_SIZE-1:0] mask_q,       mask_d;
  logic [5:0]           cards_left_q, cards_left_d;
  card_value_t          value_q,      value_d;
  card_symbol_t         symbol_q,     symbol_d;

  logic [15:0] lfsr_state;
  logic [5:0]  cand_start;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (lfsr_state)
  );

`ifdef CARD_DEALER_FIXED_SEQ_EN
  // Deterministic dealing: the LFSR keeps running but never steers the probe.
  assign cand_start  = 6'd0;
  assign unused_lfsr = ^lfsr_state;
`else
  // Only the low six LFSR bits pick the probe start.
  assign cand_start  = wrap_index(lfsr_state[5:0]);
  assign unused_lfsr = ^lfsr_state[15:6];
`endif

  // Next-state logic: shuffle first, then the IDLE/SEARCH/DONE draw sequence.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    mask_d       = mask_q;
    cards_left_d = cards_left_q;
    value_d      = value_q;
    symbol_d     = symbol_q;

    if (dif.shuffle) begin
      // Abort any draw in flight and return every card to the deck.
      state_d      = IDLE;
      mask_d       = '0;
      cards_left_d = 6'(DECK_SIZE);
    end else begin
      case (state_q)
        IDLE: begin
          if (dif.draw_req && (cards_left_q != 6'd0)) begin
            state_d = SEARCH;
            cand_d  = cand_start;
          end
        end
        SEARCH: begin
          if (!mask_q[cand_q]) begin
            // Free slot found: claim it and present the card in DONE.
            mask_d[cand_q] = 1'b1;
            cards_left_d   = cards_left_q - 6'd1;
            value_d        = index_value(cand_q);
            symbol_d       = index_symbol(cand_q);
            state_d        = DONE;
          end else begin
            cand_d = (cand_q == 6'(DECK_SIZE - 1)) ? 6'd0 : cand_q + 6'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset returns a full deck and drops any pending draw.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      mask_q       <= '0;
      cards_left_q <= 6'(DECK_SIZE);
      value_q      <= '0;
      symbol_q     <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      mask_q       <= mask_d;
      cards_left_q <= cards_left_d;
      value_q      <= value_d;
      symbol_q     <= symbol_d;
    end
  end

  assign dif.card_valid  = (state_q == DONE);
  assign dif.busy        = (state_q != IDLE);
  assign dif.card_value  = value_q;
  assign dif.card_symbol = symbol_q;
  assign dif.cards_left  = cards_left_q;
  assign dif.deck_empty  = (cards_left_q == 6'd0);

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, posedge active.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high; clock clk.
REQ-003 SHALL have port: shuffle  input  1  single-cycle pulse; returns all 52 cards to the deck.
REQ-004 SHALL have port: draw_req  input  1  single-cycle pulse; requests one card.
REQ-005 SHALL have port: card_valid  output  1  one-cycle pulse; card_value/card_symbol hold a new card.
REQ-006 SHALL have port: card_value  output  4  card rank, 1..13 (1=ace, 11..13=J/Q/K).
REQ-007 SHALL have port: card_symbol  output  2  suit, 0..3.
REQ-008 SHALL have port: busy  output  1  high while a draw is in progress.
REQ-009 SHALL have port: cards_left  output  6  number of undealt cards, 0..52.
REQ-010 SHALL have port: deck_empty  output  1  high when cards_left==0.

Function
REQ-011 SHALL keep a 52-bit used mask; card index i maps to card_value=(i mod 13)+1 and card_symbol=i div 13.
REQ-012 SHALL run a 16-bit Fibonacci LFSR every clock: taps 16,14,13,11; seed 16'hACE1; never all-zero.
REQ-013 SHALL implement FSM states IDLE, SEARCH, DONE.
REQ-014 IDLE->SEARCH: on draw_req with deck_empty==0; latch candidate = lfsr[5:0], minus 52 if >=52.
REQ-015 SEARCH: if mask[candidate]==0, mark it used and go to DONE; else candidate increments, wrapping 51->0.
REQ-016 DONE: assert card_valid for 1 cycle, decrement cards_left, then return to IDLE.
REQ-017 Latency SHALL be 2+k cycles from draw_req to card_valid, where k is the number of used slots skipped (0..51).
REQ-018 card_value/card_symbol SHALL update only in DONE and hold until the next card.
REQ-019 busy SHALL be high in SEARCH and DONE; draw_req while busy is ignored (not queued).
REQ-020 draw_req with deck_empty==1 is ignored: no state change, no card_valid.
REQ-021 shuffle SHALL clear the mask and set cards_left=52 on the next cycle, from any state.
REQ-022 shuffle during SEARCH/DONE SHALL abort to IDLE: no card_valid, no decrement; shuffle beats a simultaneous draw_req.

Reset
REQ-023 rst SHALL clear the mask and return the FSM to IDLE.
REQ-024 rst SHALL reload the LFSR seed and set cards_left=52.
REQ-025 rst SHALL drive card_valid=0, busy=0, deck_empty=0, card_value=0 and card_symbol=0; rst outranks shuffle and draw_req.
REQ-026 rst mid-SEARCH SHALL drop the pending draw without marking any card used.

Configuration
REQ-027 With CARD_DEALER_FIXED_SEQ_EN defined, the latched candidate SHALL always be 0, giving deterministic lowest-free-index dealing; the LFSR keeps running but is unused.
REQ-028 Without CARD_DEALER_FIXED_SEQ_EN, the candidate comes from the LFSR as in REQ-014.

Structure
REQ-029 Shared package blackjack_pkg SHALL hold card_value_t (4b), card_symbol_t (2b), DECK_SIZE=52, SUIT_SIZE=13, LFSR_SEED=16'hACE1.
REQ-030 The LFSR SHALL be a separate sub-module lfsr16 (clk, rst, 16-bit state out); the rest of the logic stays in card_dealer.

Verification (all with CARD_DEALER_FIXED_SEQ_EN)
REQ-031 Reset, then draw_req at cycle N -> card_valid at N+2, value=1, symbol=0, cards_left=51.
REQ-032 14 back-to-back draws, each issued after the previous card_valid -> 14th card value=1, symbol=1, latency 2+13 cycles.
REQ-033 52 draws -> cards_left=0, deck_empty=1; a 53rd draw_req -> no card_valid, busy stays 0.
REQ-034 shuffle one cycle after draw_req -> no card_valid, cards_left=52; next draw -> value=1, symbol=0.
REQ-035 draw_req pulsed again while busy -> exactly one card_valid; draw_req and shuffle in the same cycle -> shuffle only.
REQ-036 rst asserted in SEARCH after 5 dealt cards -> cards_left=52, card_value=0; next draw -> value=1, symbol=0.
